game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer.sv | 151 +++++++++++++++
 tb/tb_game_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Runner-game sequencer: IDLE/RUN/DEAD state machine that moves the obstacle,
// detects dino collisions, keeps a BCD score and ramps obstacle speed.
module game_sequencer #(
    parameter logic [6:0] OBST_START = 7'd127,
    parameter logic [6:0] DINO_X     = 7'd8,
    parameter logic [6:0] DINO_W     = 7'd8,
    parameter logic [5:0] OBST_H     = 6'd10,
    parameter logic [3:0] SPEED_STEP = 4'd5,
    parameter logic [2:0] MAX_SPEED  = 3'd4,
    parameter logic [5:0] DEAD_HOLD  = 6'd30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        btn,
    input  logic [5:0]  dino_y,
    output logic [1:0]  game_state,
    output logic [6:0]  obstacle_x,
    output logic [2:0]  speed,
    output logic [15:0] score,
    output logic        game_over
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [6:0]  obstacle_x_nxt;
    logic [2:0]  speed_nxt;
    logic [15:0] score_nxt;
    logic        game_over_nxt;
    logic [3:0]  step_cnt, step_cnt_nxt, step_inc;
    logic [5:0]  hold_cnt, hold_cnt_nxt;
    logic        btn_q;
    logic        btn_edge;
    logic        collide;

    // Packed-BCD increment with per-digit carry, saturating at 9999.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        logic [3:0]  d;
        r = v;
        c = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                d = v[4*i +: 4];
                if (c) begin
                    if (d == 4'd9) begin
                        d = 4'd0;
                    end else begin
                        d = d + 4'd1;
                        c = 1'b0;
                    end
                end
                r[4*i +: 4] = d;
            end
        end
        return r;
    endfunction

    assign btn_edge = btn & ~btn_q;
    assign collide  = (obstacle_x >= DINO_X) &&
                      (obstacle_x <= 7'(DINO_X + DINO_W - 7'd1)) &&
                      (dino_y < OBST_H);
    assign step_inc = step_cnt + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            obstacle_x <= OBST_START;
            speed      <= 3'd1;
            score      <= 16'h0000;
            game_over  <= 1'b0;
            step_cnt   <= 4'd0;
            hold_cnt   <= 6'd0;
            btn_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            obstacle_x <= obstacle_x_nxt;
            speed      <= speed_nxt;
            score      <= score_nxt;
            game_over  <= game_over_nxt;
            step_cnt   <= step_cnt_nxt;
            hold_cnt   <= hold_cnt_nxt;
            btn_q      <= btn;
        end
    end

    always_comb begin
        state_nxt      = state;
        obstacle_x_nxt = obstacle_x;
        speed_nxt      = speed;
        score_nxt      = score;
        game_over_nxt  = 1'b0;
        step_cnt_nxt   = step_cnt;
        hold_cnt_nxt   = hold_cnt;
        case (state)
            IDLE: begin
                if (btn_edge) begin
                    state_nxt      = RUN;
                    obstacle_x_nxt = OBST_START;
                    speed_nxt      = 3'd1;
                    score_nxt      = 16'h0000;
                    step_cnt_nxt   = 4'd0;
                end
            end
            RUN: begin
                // Collision is judged on the pre-move obstacle position.
                if (frame_tick) begin
                    if (collide) begin
                        state_nxt     = DEAD;
                        game_over_nxt = 1'b1;
                        hold_cnt_nxt  = 6'd0;
                    end else if (obstacle_x >= 7'(speed)) begin
                        obstacle_x_nxt = obstacle_x - 7'(speed);
                    end else begin
                        obstacle_x_nxt = OBST_START;
                        score_nxt      = bcd_inc(score);
                        if (step_inc == SPEED_STEP) begin
                            step_cnt_nxt = 4'd0;
                            if (speed < MAX_SPEED) begin
                                speed_nxt = speed + 3'd1;
                            end
                        end else begin
                            step_cnt_nxt = step_inc;
                        end
                    end
                end
            end
            DEAD: begin
                if (btn_edge && (hold_cnt == DEAD_HOLD)) begin
                    state_nxt      = RUN;
                    obstacle_x_nxt = OBST_START;
                    speed_nxt      = 3'd1;
                    score_nxt      = 16'h0000;
                    step_cnt_nxt   = 4'd0;
                end else if (frame_tick && (hold_cnt < DEAD_HOLD)) begin
                    hold_cnt_nxt = hold_cnt + 6'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign game_state = state;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: start, collision, dead hold, speed ramp,
// BCD score, async reset and button-held-through-reset behaviour.
module tb_game_sequencer;

    logic        clk;
    logic        rst_n;
    logic        frame_tick;
    logic        btn;
    logic [5:0]  dino_y;
    logic [1:0]  game_state;
    logic [6:0]  obstacle_x;
    logic [2:0]  speed;
    logic [15:0] score;
    logic        game_over;

    int n_cmp;
    int n_err;

    game_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .btn        (btn),
        .dino_y     (dino_y),
        .game_state (game_state),
        .obstacle_x (obstacle_x),
        .speed      (speed),
        .score      (score),
        .game_over  (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One frame_tick pulse; returns at the negedge after it was sampled.
    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
        end
    endtask

    task automatic press();
        @(negedge clk);
        btn = 1'b1;
        @(negedge clk);
        btn = 1'b0;
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        frame_tick = 1'b0;
        btn        = 1'b0;
        dino_y     = 6'd0;
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(game_state), 32'd0);
        chk("rst_x", 32'(obstacle_x), 32'd127);
        chk("rst_speed", 32'(speed), 32'd1);
        chk("rst_score", 32'(score), 32'h0);
        chk("rst_go", 32'(game_over), 32'd0);
        rst_n = 1'b1;

        tick_n(3);
        chk("idle_state", 32'(game_state), 32'd0);
        chk("idle_x", 32'(obstacle_x), 32'd127);

        press();
        chk("start_state", 32'(game_state), 32'd1);
        chk("start_x", 32'(obstacle_x), 32'd127);

        tick_n(112);
        chk("pre_hit_x", 32'(obstacle_x), 32'd15);
        chk("pre_hit_state", 32'(game_state), 32'd1);
        tick_n(1);
        chk("hit_state", 32'(game_state), 32'd2);
        chk("hit_go", 32'(game_over), 32'd1);
        chk("hit_x", 32'(obstacle_x), 32'd15);
        chk("hit_score", 32'(score), 32'h0);
        @(negedge clk);
        chk("go_pulse_end", 32'(game_over), 32'd0);

        tick_n(10);
        press();
        chk("early_restart", 32'(game_state), 32'd2);
        chk("dead_x_hold", 32'(obstacle_x), 32'd15);
        tick_n(20);
        press();
        chk("restart_state", 32'(game_state), 32'd1);
        chk("restart_score", 32'(score), 32'h0);
        chk("restart_x", 32'(obstacle_x), 32'd127);
        chk("restart_speed", 32'(speed), 32'd1);

        dino_y = 6'd20;
        press();
        chk("run_btn_state", 32'(game_state), 32'd1);
        chk("run_btn_x", 32'(obstacle_x), 32'd127);

        tick_n(128);
        chk("wrap1_x", 32'(obstacle_x), 32'd127);
        chk("wrap1_score", 32'(score), 32'h1);
        chk("wrap1_speed", 32'(speed), 32'd1);
        tick_n(512);
        chk("wrap5_score", 32'(score), 32'h5);
        chk("wrap5_speed", 32'(speed), 32'd2);
        tick_n(320);
        chk("wrap10_score", 32'(score), 32'h10);
        chk("wrap10_speed", 32'(speed), 32'd3);
        tick_n(215);
        chk("wrap15_score", 32'(score), 32'h15);
        chk("wrap15_speed", 32'(speed), 32'd4);
        tick_n(160);
        chk("wrap20_score", 32'(score), 32'h20);
        chk("wrap20_speed", 32'(speed), 32'd4);
        tick_n(160);
        chk("wrap25_score", 32'(score), 32'h25);
        chk("wrap25_speed", 32'(speed), 32'd4);
        chk("wrap25_x", 32'(obstacle_x), 32'd127);
        tick_n(1);
        chk("speed4_step_x", 32'(obstacle_x), 32'd123);

        // Asynchronous reset asserted between clock edges.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_state", 32'(game_state), 32'd0);
        chk("async_x", 32'(obstacle_x), 32'd127);
        chk("async_speed", 32'(speed), 32'd1);
        chk("async_score", 32'(score), 32'h0);

        btn = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("held_btn_start", 32'(game_state), 32'd1);
        repeat (3) @(negedge clk);
        btn = 1'b0;

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        btn        = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        btn        = 1'b0;
        frame_tick = 1'b0;
        chk("coinc_state", 32'(game_state), 32'd1);
        chk("coinc_x", 32'(obstacle_x), 32'd127);
        tick_n(1);
        chk("coinc_next_x", 32'(obstacle_x), 32'd126);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
